pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush/forward controller for the 5-stage RV32 pipeline; replaces the separate hazard and
//  forwarding units. Generalised to FWD_SRC forwarding stages; adds variable-latency data-memory wait
//  (req/ack), memory-timeout detection, a halt-drain FSM and a saturating stall-cycle counter.
// PARAMETERS
//  RF_ADDRESS   5    register index width
//  FWD_SRC      2    forwarding sources after EX; index 0 = EX/MEM (youngest), FWD_SRC-1 = oldest
//  MEM_TIMEOUT  64   consecutive wait cycles before mem_timeout_err sets
//  CNT_W        16   stall_cycles width
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous, active-high
//  id_rs1/id_rs2    in   RF_ADDRESS         source regs of instr in ID
//  id_use_rs1/rs2   in   1                  instr in ID actually reads rs1/rs2
//  ex_rs1/ex_rs2    in   RF_ADDRESS         source regs of instr in EX
//  ex_rd            in   RF_ADDRESS         dest reg of instr in EX
//  ex_memread       in   1                  instr in EX is a load
//  ex_br_taken      in   1                  EX redirects PC (branch/jal/jalr)
//  ex_halt          in   1                  halt instr in EX
//  fwd_rd           in   FWD_SRC*RF_ADDRESS dest regs of later stages, slice i = source i
//  fwd_regwrite     in   FWD_SRC            later stage i writes fwd_rd[i]
//  mem_req          in   1                  MEM stage access outstanding
//  mem_ack          in   1                  data memory completes this cycle
//  pc_en,if_id_en,id_ex_en,ex_mem_en out 1  stage load enables
//  if_id_flush,id_ex_flush   out 1          load bubble into IF/ID, ID/EX
//  mem_wb_bubble    out  1                  load bubble into MEM/WB
//  fwd_a_sel/b_sel  out  $clog2(FWD_SRC+1)  0 = register file, i+1 = source i
//  halted           out  1                  pipeline drained after halt
//  mem_timeout_err  out  1                  sticky timeout flag
//  stall_cycles     out  CNT_W              cycles with pc_en=0 in RUN, saturating
// BEHAVIOUR
//  Reset: FSM=RUN, halted=0, mem_timeout_err=0, stall_cycles=0, wait/drain counters=0; all combinational
//   outputs then follow RUN rules below (with idle inputs: all enables 1, flushes 0, fwd sels 0).
//  Forwarding (comb): sel = i+1 for smallest i with fwd_regwrite[i] & fwd_rd[i]==ex_rsX & ex_rsX!=0;
//   else 0. Youngest source wins; x0 never forwarded.
//  mem_wait = mem_req & ~mem_ack. Priority per cycle: HALTED > mem_wait > DRAIN > branch > load-use.
//  mem_wait: pc_en=if_id_en=id_ex_en=ex_mem_en=0, flushes 0, mem_wb_bubble=1. A pending branch or halt
//   in EX is held and acted on the first cycle mem_wait=0.
//  Branch (ex_br_taken, RUN, no wait): pc_en=1, if_id_flush=1, id_ex_flush=1; overrides load-use.
//  Load-use: ex_memread & ex_rd!=0 & (id_use_rs1&id_rs1==ex_rd | id_use_rs2&id_rs2==ex_rd):
//   pc_en=0, if_id_en=0, id_ex_flush=1; exactly one bubble per matching load.
//  Halt FSM (state enum in package): RUN -> DRAIN on ex_halt & ~mem_wait (branch ignored that cycle);
//   drain counter loaded with FWD_SRC+1. DRAIN: pc_en=0, if_id_flush=1, id_ex_flush=1, later stages run;
//   counter decrements on cycles with mem_wait=0; at 1 -> HALTED. HALTED: all enables 0, flushes 0,
//   mem_wb_bubble=1, halted=1. Only reset exits HALTED.
//  Timeout: wait counter counts consecutive mem_wait cycles, clears when mem_wait=0; reaching MEM_TIMEOUT
//   sets mem_timeout_err (sticky until reset); stall continues, no forced ack.
//  stall_cycles: +1 on each RUN cycle with pc_en=0 (load-use or wait), saturates at all-ones.
//  Reset mid-wait/drain: returns to RUN same edge, counters cleared; no output glitch beyond reset values.
// STRUCTURE
//  pipe_ctrl_pkg: ctrl_state_e {RUN,DRAIN,HALTED}, FWD_SEL_RF constant, fwd-sel width function.
//  Sub-module fwd_select (priority comparator over FWD_SRC sources), instantiated for operand A and B.
//  Rest: comb priority block + FSM/counters in one always_ff.
// TESTING
//  1 fwd: fwd_rd={x5,x5}, both regwrite, ex_rs1=x5 -> fwd_a_sel=1; rs1=x0 same sources -> 0.
//  2 load-use: ex_memread, ex_rd=x7, id_rs2=x7, id_use_rs2 -> one cycle pc_en=0, id_ex_flush=1, stall_cycles=1.
//  3 load-use + ex_br_taken same cycle -> pc_en=1, both flushes 1, stall_cycles unchanged.
//  4 mem_req held, ack at cycle 5 -> 4 cycles all enables 0, bubble=1; MEM_TIMEOUT=3 -> err set, stays set.
//  5 ex_halt with FWD_SRC=2 -> 3 DRAIN cycles then halted=1, enables 0; reset -> RUN, halted=0.
//  6 ex_halt during mem_wait -> DRAIN entered only after ack; drain count paused by later waits.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush/forward controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    // Operand mux select value meaning "take the register file output".
    localparam int FWD_SEL_RF = 0;

    // Select width for a mux over the register file plus n forwarding sources.
    function automatic int fwd_sel_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority comparator choosing the youngest later-stage source that writes the
// register read by one EX operand; x0 is never forwarded.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int RF_ADDRESS = 5,
    parameter int FWD_SRC    = 2,
    parameter int SEL_W      = fwd_sel_w(FWD_SRC)
) (
    input  logic [RF_ADDRESS-1:0]         rs,
    input  logic [FWD_SRC*RF_ADDRESS-1:0] fwd_rd,
    input  logic [FWD_SRC-1:0]            fwd_regwrite,
    output logic [SEL_W-1:0]              sel
);

    logic [FWD_SRC-1:0] hit;

    generate
        for (genvar gi = 0; gi < FWD_SRC; gi++) begin : g_cmp
            assign hit[gi] = fwd_regwrite[gi]
                          && (fwd_rd[gi*RF_ADDRESS +: RF_ADDRESS] == rs)
                          && (rs != '0);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching index is the final winner.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        for (int i = FWD_SRC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = SEL_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage RV32 pipeline with
// memory wait handling, timeout detection, halt drain and stall statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RF_ADDRESS  = 5,
    parameter int FWD_SRC     = 2,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [RF_ADDRESS-1:0]             id_rs1,
    input  logic [RF_ADDRESS-1:0]             id_rs2,
    input  logic                              id_use_rs1,
    input  logic                              id_use_rs2,
    input  logic [RF_ADDRESS-1:0]             ex_rs1,
    input  logic [RF_ADDRESS-1:0]             ex_rs2,
    input  logic [RF_ADDRESS-1:0]             ex_rd,
    input  logic                              ex_memread,
    input  logic                              ex_br_taken,
    input  logic                              ex_halt,
    input  logic [FWD_SRC*RF_ADDRESS-1:0]     fwd_rd,
    input  logic [FWD_SRC-1:0]                fwd_regwrite,
    input  logic                              mem_req,
    input  logic                              mem_ack,
    output logic                              pc_en,
    output logic                              if_id_en,
    output logic                              id_ex_en,
    output logic                              ex_mem_en,
    output logic                              if_id_flush,
    output logic                              id_ex_flush,
    output logic                              mem_wb_bubble,
    output logic [fwd_sel_w(FWD_SRC)-1:0]     fwd_a_sel,
    output logic [fwd_sel_w(FWD_SRC)-1:0]     fwd_b_sel,
    output logic                              halted,
    output logic                              mem_timeout_err,
    output logic [CNT_W-1:0]                  stall_cycles
);

    localparam int SEL_W   = fwd_sel_w(FWD_SRC);
    localparam int DRAIN_W = $clog2(FWD_SRC + 2);
    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e        state_reg;
    logic [DRAIN_W-1:0] drain_cnt_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic               err_reg;
    logic               halted_reg;
    logic [CNT_W-1:0]   stall_reg;

    logic mem_wait;
    logic load_use;

    fwd_select #(
        .RF_ADDRESS   (RF_ADDRESS),
        .FWD_SRC      (FWD_SRC),
        .SEL_W        (SEL_W)
    ) u_fwd_a (
        .rs           (ex_rs1),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .sel          (fwd_a_sel)
    );

    fwd_select #(
        .RF_ADDRESS   (RF_ADDRESS),
        .FWD_SRC      (FWD_SRC),
        .SEL_W        (SEL_W)
    ) u_fwd_b (
        .rs           (ex_rs2),
        .fwd_rd       (fwd_rd),
        .fwd_regwrite (fwd_regwrite),
        .sel          (fwd_b_sel)
    );

    assign mem_wait = mem_req & ~mem_ack;
    assign load_use = ex_memread && (ex_rd != '0)
                   && ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Priority: halted, memory wait, drain, branch, load-use. The cycle a halt
    // is accepted runs normally except that a simultaneous branch is dropped.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (state_reg == HALTED || mem_wait) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (state_reg == DRAIN) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ex_br_taken && !ex_halt) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            drain_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            halted_reg    <= 1'b0;
            stall_reg     <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ex_halt && !mem_wait) begin
                        state_reg     <= DRAIN;
                        drain_cnt_reg <= DRAIN_W'(FWD_SRC + 1);
                    end
                end
                DRAIN: begin
                    // Drain progress freezes while memory holds the back end.
                    if (!mem_wait) begin
                        if (drain_cnt_reg == DRAIN_W'(1)) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                        end
                        drain_cnt_reg <= drain_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= HALTED;
                end
            endcase

            if (mem_wait) begin
                if (wait_cnt_reg != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    err_reg <= 1'b1;
                end
            end else begin
                wait_cnt_reg <= '0;
            end

            if (state_reg == RUN && !pc_en && stall_reg != {CNT_W{1'b1}}) begin
                stall_reg <= stall_reg + 1'b1;
            end
        end
    end

    assign halted          = halted_reg;
    assign mem_timeout_err = err_reg;
    assign stall_cycles    = stall_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch, memory
// wait/timeout, stall saturation and halt drain, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int RF  = 5;
    localparam int FS  = 2;
    localparam int SW  = 2;

    // Packed control view: {pc_en,if_id_en,id_ex_en,ex_mem_en,if_id_flush,id_ex_flush,mem_wb_bubble}
    localparam logic [6:0] C_IDLE  = 7'b1111000;
    localparam logic [6:0] C_LU    = 7'b0011010;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_WAIT  = 7'b0000001;
    localparam logic [6:0] C_DRAIN = 7'b0111110;
    localparam logic [6:0] C_HALT  = 7'b0000001;

    logic             clk = 1'b0;
    logic             reset;
    logic [RF-1:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, ex_halt;
    logic [FS*RF-1:0] fwd_rd;
    logic [FS-1:0]    fwd_regwrite;
    logic             mem_req, mem_ack;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [SW-1:0]    fwd_a_sel, fwd_b_sel;
    logic             halted, mem_timeout_err;
    logic [3:0]       stall_cycles;
    logic [6:0]       ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};

    pipe_hazard_ctrl #(
        .RF_ADDRESS      (RF),
        .FWD_SRC         (FS),
        .MEM_TIMEOUT     (3),
        .CNT_W           (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_br_taken     (ex_br_taken),
        .ex_halt         (ex_halt),
        .fwd_rd          (fwd_rd),
        .fwd_regwrite    (fwd_regwrite),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .halted          (halted),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_br_taken = 1'b0; ex_halt = 1'b0; fwd_rd = '0; fwd_regwrite = '0;
        mem_req = 1'b0; mem_ack = 1'b0;
        do_reset();

        chk("rst_ctl", 32'(ctl), 32'(C_IDLE));
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(mem_timeout_err), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 0);

        // Forwarding priority and x0 exclusion
        fwd_rd = {5'd5, 5'd5}; fwd_regwrite = 2'b11; ex_rs1 = 5'd5; ex_rs2 = 5'd5; #1;
        chk("fwd_a_young", 32'(fwd_a_sel), 1);
        fwd_regwrite = 2'b10; #1;
        chk("fwd_b_old", 32'(fwd_b_sel), 2);
        fwd_regwrite = 2'b11; ex_rs1 = 5'd0; fwd_rd = {5'd0, 5'd0}; #1;
        chk("fwd_a_x0", 32'(fwd_a_sel), 0);
        fwd_rd = {5'd9, 5'd3}; ex_rs2 = 5'd9; #1;
        chk("fwd_b_src1", 32'(fwd_b_sel), 2);
        fwd_regwrite = 2'b00; #1;
        chk("fwd_b_nowr", 32'(fwd_b_sel), 0);
        fwd_rd = '0; ex_rs2 = '0;

        // Load-use on rs2
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        ex_memread = 1'b0; ex_rd = '0; #1;
        chk("lu_after_ctl", 32'(ctl), 32'(C_IDLE));
        chk("lu_stall", 32'(stall_cycles), 1);
        ex_memread = 1'b1; ex_rd = 5'd7; id_use_rs2 = 1'b0; #1;
        chk("lu_nouse", 32'(ctl), 32'(C_IDLE));
        ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
        chk("lu_x0", 32'(ctl), 32'(C_IDLE));

        // Branch overrides load-use
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_use_rs1 = 1'b0; ex_br_taken = 1'b1; #1;
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        tick();
        ex_memread = 1'b0; ex_rd = '0; id_rs2 = '0; id_use_rs2 = 1'b0; ex_br_taken = 1'b0; #1;
        chk("br_stall", 32'(stall_cycles), 1);

        // Four wait cycles, ack on the fifth; timeout after three
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("wait%0d_ctl", c), 32'(ctl), 32'(C_WAIT));
            chk($sformatf("wait%0d_err", c), 32'(mem_timeout_err), (c >= 4) ? 1 : 0);
            tick();
        end
        mem_ack = 1'b1; #1;
        chk("ack_ctl", 32'(ctl), 32'(C_IDLE));
        chk("ack_stall", 32'(stall_cycles), 5);
        tick();
        mem_req = 1'b0; mem_ack = 1'b0; #1;
        chk("err_sticky", 32'(mem_timeout_err), 1);

        // Stall counter saturation (4-bit counter)
        mem_req = 1'b1;
        repeat (12) tick();
        mem_req = 1'b0; #1;
        chk("stall_sat", 32'(stall_cycles), 15);
        tick();
        chk("stall_sat_hold", 32'(stall_cycles), 15);

        do_reset();
        chk("rst2_err", 32'(mem_timeout_err), 0);
        chk("rst2_stall", 32'(stall_cycles), 0);

        // Halt drain: accept cycle, 3 DRAIN cycles, then HALTED
        ex_halt = 1'b1; ex_br_taken = 1'b1; #1;
        chk("halt_accept_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        ex_halt = 1'b0; ex_br_taken = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("drain%0d_ctl", c), 32'(ctl), 32'(C_DRAIN));
            chk($sformatf("drain%0d_halted", c), 32'(halted), 0);
            tick();
        end
        chk("halted", 32'(halted), 1);
        chk("halted_ctl", 32'(ctl), 32'(C_HALT));
        ex_br_taken = 1'b1;
        tick();
        chk("halted_stay_ctl", 32'(ctl), 32'(C_HALT));
        chk("halted_stall", 32'(stall_cycles), 0);
        ex_br_taken = 1'b0;
        do_reset();
        chk("rst3_halted", 32'(halted), 0);
        chk("rst3_ctl", 32'(ctl), 32'(C_IDLE));

        // Halt during memory wait; drain paused by later waits
        ex_halt = 1'b1; mem_req = 1'b1; mem_ack = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            chk($sformatf("hw%0d_ctl", c), 32'(ctl), 32'(C_WAIT));
            tick();
        end
        mem_ack = 1'b1; #1;
        chk("hw_accept_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        ex_halt = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; #1;
        chk("hw_drain1_ctl", 32'(ctl), 32'(C_DRAIN));
        tick();
        mem_req = 1'b1; #1;
        chk("hw_pause_ctl", 32'(ctl), 32'(C_WAIT));
        tick();
        tick();
        mem_req = 1'b0; #1;
        chk("hw_drain2_ctl", 32'(ctl), 32'(C_DRAIN));
        chk("hw_drain2_halted", 32'(halted), 0);
        tick();
        chk("hw_drain3_ctl", 32'(ctl), 32'(C_DRAIN));
        tick();
        chk("hw_halted", 32'(halted), 1);
        chk("hw_stall", 32'(stall_cycles), 2);
        chk("hw_err", 32'(mem_timeout_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
